// File: rtl/ex_mem_buf_if.sv
// Execute-to-memory result bus for ex_mem_buf; forwarding query signals exist
// only when EX_MEM_BUF_BYPASS_EN is defined.
interface ex_mem_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_waddr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              flush_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic [DATA_W-1:0] mem_wdata_o;
`ifdef EX_MEM_BUF_BYPASS_EN
  logic [ADDR_W-1:0] id_raddr_i;
  logic              fwd_hit_o;
  logic [DATA_W-1:0] fwd_data_o;
`endif

  modport slave (
    input  ex_valid_i, ex_we_i, ex_waddr_i, ex_wdata_i, flush_i, mem_ready_i,
`ifdef EX_MEM_BUF_BYPASS_EN
    input  id_raddr_i,
    output fwd_hit_o, fwd_data_o,
`endif
    output ex_ready_o, mem_valid_o, mem_we_o, mem_waddr_o, mem_wdata_o
  );

  modport master (
    output ex_valid_i, ex_we_i, ex_waddr_i, ex_wdata_i, flush_i, mem_ready_i,
`ifdef EX_MEM_BUF_BYPASS_EN
    output id_raddr_i,
    input  fwd_hit_o, fwd_data_o,
`endif
    input  ex_ready_o, mem_valid_o, mem_we_o, mem_waddr_o, mem_wdata_o
  );
endinterface

// File: rtl/ex_mem_buf.sv
// Two-entry in-order EX/MEM result buffer with flush.
// Define EX_MEM_BUF_BYPASS_EN to build the decode-stage forwarding comparators.
module ex_mem_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic          clk,
  input logic          rst,
  ex_mem_buf_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        we_q;
  logic [ADDR_W-1:0] waddr_q [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic              accept, pop, mem_valid;

  assign mem_valid = (state_q != EMPTY);

  always_comb begin
    accept  = bus.ex_valid_i && (state_q != FULL);
    pop     = mem_valid && bus.mem_ready_i;
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      if (accept) wr_d = ~wr_q;
      if (pop)    rd_d = ~rd_q;
      unique case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !pop)      state_d = FULL;
          else if (pop && !accept) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      we_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      // Writes to r0 are stored but never marked as register writes.
      if (accept && !bus.flush_i) begin
        we_q[wr_q]    <= bus.ex_we_i && (bus.ex_waddr_i != '0);
        waddr_q[wr_q] <= bus.ex_waddr_i;
        wdata_q[wr_q] <= bus.ex_wdata_i;
      end
    end
  end

  assign bus.ex_ready_o  = (state_q != FULL);
  assign bus.mem_valid_o = mem_valid;
  assign bus.mem_we_o    = mem_valid && we_q[rd_q];
  assign bus.mem_waddr_o = mem_valid ? waddr_q[rd_q] : '0;
  assign bus.mem_wdata_o = mem_valid ? wdata_q[rd_q] : '0;

`ifdef EX_MEM_BUF_BYPASS_EN
  logic tail_idx, hit_head, hit_tail;

  // When FULL the non-head slot holds the younger entry and wins on a double match.
  assign tail_idx = ~rd_q;
  assign hit_head = mem_valid && we_q[rd_q] && (bus.id_raddr_i != '0)
                    && (waddr_q[rd_q] == bus.id_raddr_i);
  assign hit_tail = (state_q == FULL) && we_q[tail_idx] && (bus.id_raddr_i != '0)
                    && (waddr_q[tail_idx] == bus.id_raddr_i);

  assign bus.fwd_hit_o  = hit_head || hit_tail;
  assign bus.fwd_data_o = hit_tail ? wdata_q[tail_idx] :
                          hit_head ? wdata_q[rd_q] : '0;
`endif
endmodule

// File: tb/tb_ex_mem_buf.sv
// Directed vector bench for ex_mem_buf: each row's expectations are the outputs
// seen during that cycle, before its inputs take effect at the next rising edge.
module tb_ex_mem_buf;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          v;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          mr;
    logic [AW-1:0] ra;
    logic          e_er;
    logic          e_mv;
    logic          e_mwe;
    logic [AW-1:0] e_mwa;
    logic [DW-1:0] e_mwd;
    logic          e_fh;
    logic [DW-1:0] e_fd;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t vecs [$];

  ex_mem_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ex_mem_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic v, input logic we,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic mr,
                     input logic [AW-1:0] ra, input logic er, input logic mv,
                     input logic mwe, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                     input logic fh, input logic [DW-1:0] fd);
    vec_t t;
    t.rst = r; t.flush = f; t.v = v; t.we = we; t.wa = wa; t.wd = wd; t.mr = mr; t.ra = ra;
    t.e_er = er; t.e_mv = mv; t.e_mwe = mwe; t.e_mwa = mwa; t.e_mwd = mwd;
    t.e_fh = fh; t.e_fd = fd;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    rst                = t.rst;
    bus.flush_i        = t.flush;
    bus.ex_valid_i     = t.v;
    bus.ex_we_i        = t.we;
    bus.ex_waddr_i     = t.wa;
    bus.ex_wdata_i     = t.wd;
    bus.mem_ready_i    = t.mr;
`ifdef EX_MEM_BUF_BYPASS_EN
    bus.id_raddr_i     = t.ra;
`endif
  endtask

  task automatic check_outs(input string tag, input logic er, input logic mv, input logic mwe,
                            input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                            input logic fh, input logic [DW-1:0] fd);
    chk({tag, ".ex_ready"},  DW'(bus.ex_ready_o),  DW'(er));
    chk({tag, ".mem_valid"}, DW'(bus.mem_valid_o), DW'(mv));
    chk({tag, ".mem_we"},    DW'(bus.mem_we_o),    DW'(mwe));
    chk({tag, ".mem_waddr"}, DW'(bus.mem_waddr_o), DW'(mwa));
    chk({tag, ".mem_wdata"}, bus.mem_wdata_o,      mwd);
`ifdef EX_MEM_BUF_BYPASS_EN
    chk({tag, ".fwd_hit"},   DW'(bus.fwd_hit_o),   DW'(fh));
    chk({tag, ".fwd_data"},  bus.fwd_data_o,       fd);
`else
    if (fh === 1'bx || fd === 'x) $display("note: %s has undefined forwarding expectation", tag);
`endif
  endtask

  initial begin
    vec_t idle;
    n_cmp = 0;
    n_bad = 0;

    //  rst f v we wa  wd            mr ra | er mv mwe mwa mwd         fh fd
    // Single push, one-cycle latency, drain
    add(0,0,1,1,3,32'h0000_1234, 1,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,0,0,0,32'h0,         1,3,  1,1,1,3,32'h0000_1234, 1,32'h0000_1234);
    add(0,0,0,0,0,32'h0,         0,0,  1,0,0,0,32'h0,         0,32'h0);
    // Fill with A, B; third push refused; in-order drain
    add(0,0,1,1,1,32'hA,         0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,1,1,2,32'hB,         0,0,  1,1,1,1,32'hA,         0,32'h0);
    add(0,0,1,1,7,32'hC,         0,2,  0,1,1,1,32'hA,         1,32'hB);
    add(0,0,0,0,0,32'h0,         1,0,  0,1,1,1,32'hA,         0,32'h0);
    add(0,0,0,0,0,32'h0,         1,0,  1,1,1,2,32'hB,         0,32'h0);
    add(0,0,0,0,0,32'h0,         0,7,  1,0,0,0,32'h0,         0,32'h0);
    // ONE with simultaneous push and pop
    add(0,0,1,1,4,32'hD,         0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,1,1,6,32'hC,         1,0,  1,1,1,4,32'hD,         0,32'h0);
    add(0,0,0,0,0,32'h0,         0,4,  1,1,1,6,32'hC,         0,32'h0);
    add(0,0,0,0,0,32'h0,         1,0,  1,1,1,6,32'hC,         0,32'h0);
    add(0,0,0,0,0,32'h0,         0,0,  1,0,0,0,32'h0,         0,32'h0);
    // Flush while FULL with a push and pop offered
    add(0,0,1,1,1,32'h11,        0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,1,1,2,32'h22,        0,0,  1,1,1,1,32'h11,        0,32'h0);
    add(0,1,1,1,3,32'h33,        1,0,  0,1,1,1,32'h11,        0,32'h0);
    add(0,0,0,0,0,32'h0,         0,3,  1,0,0,0,32'h0,         0,32'h0);
    // Reset while FULL
    add(0,0,1,1,1,32'h44,        0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,1,1,2,32'h55,        0,0,  1,1,1,1,32'h44,        0,32'h0);
    add(1,0,1,1,3,32'h66,        1,0,  0,1,1,1,32'h44,        0,32'h0);
    add(0,0,0,0,0,32'h0,         0,3,  1,0,0,0,32'h0,         0,32'h0);
    // Write to r0 is suppressed
    add(0,0,1,1,0,32'hFFFF_FFFF, 0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,0,0,0,32'h0,         0,0,  1,1,0,0,32'hFFFF_FFFF, 0,32'h0);
    add(0,0,0,0,0,32'h0,         1,0,  1,1,0,0,32'hFFFF_FFFF, 0,32'h0);
    // Forwarding picks the youngest match
    add(0,0,1,1,5,32'h11,        0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,1,1,5,32'h22,        0,5,  1,1,1,5,32'h11,        1,32'h11);
    add(0,0,0,0,0,32'h0,         0,5,  0,1,1,5,32'h11,        1,32'h22);
    add(0,0,0,0,0,32'h0,         0,6,  0,1,1,5,32'h11,        0,32'h0);
    add(0,0,0,0,0,32'h0,         1,5,  0,1,1,5,32'h11,        1,32'h22);
    add(0,0,0,0,0,32'h0,         1,5,  1,1,1,5,32'h22,        1,32'h22);
    add(0,0,0,0,0,32'h0,         0,5,  1,0,0,0,32'h0,         0,32'h0);
    // we=0 entry is never a forwarding source
    add(0,0,1,0,7,32'h77,        0,0,  1,0,0,0,32'h0,         0,32'h0);
    add(0,0,0,0,0,32'h0,         1,7,  1,1,0,7,32'h77,        0,32'h0);
    add(0,0,0,0,0,32'h0,         0,0,  1,0,0,0,32'h0,         0,32'h0);

    idle = vecs[vecs.size()-1];

    // Reset with garbage on the inputs, then check reset outputs
    drive(idle);
    bus.ex_valid_i = 1'b1;
    bus.ex_waddr_i = 5'd9;
    bus.ex_wdata_i = 32'hDEAD_BEEF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(idle);
    #1;
    check_outs("reset", 1, 0, 0, 0, 32'h0, 0, 32'h0);

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].e_er, vecs[i].e_mv, vecs[i].e_mwe,
                 vecs[i].e_mwa, vecs[i].e_mwd, vecs[i].e_fh, vecs[i].e_fd);
      @(posedge clk);
    end

    // Head fields hold steady across a multi-cycle stall while FULL
    @(negedge clk);
    drive(idle);
    bus.ex_valid_i = 1'b1; bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd9; bus.ex_wdata_i = 32'h9999;
    @(negedge clk);
    bus.ex_waddr_i = 5'd10; bus.ex_wdata_i = 32'hAAAA;
    @(negedge clk);
    bus.ex_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_outs($sformatf("stall%0d", k), 0, 1, 1, 5'd9, 32'h9999, 0, 32'h0);
      @(negedge clk);
    end
    bus.mem_ready_i = 1'b1;
    #1;
    check_outs("stall_pop0", 0, 1, 1, 5'd9, 32'h9999, 0, 32'h0);
    @(negedge clk);
    #1;
    check_outs("stall_pop1", 1, 1, 1, 5'd10, 32'hAAAA, 0, 32'h0);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    check_outs("stall_end", 1, 0, 0, 0, 32'h0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
